spi_cmd_ctrl: RTL
=================

Name: spi_cmd_ctrl

Overview:
Command controller that sequences the SPI slave byte interface. It decodes bytes received from the SPI master and executes the command. For GET_STATE it returns the status FSM state. It also gives the master read/write access to a small bank of 8-bit control registers that drive board logic. It sits between the SPI slave instance (RX/TX byte handshake) and user logic, and replaces ad-hoc per-command polling in the top level.

Parameters:
STATE_W, 2, width of the FSM state input returned by GET_STATE
NUM_REGS, 3, number of writable control registers (addresses 0..NUM_REGS-1; max 3)
REG_RST, 8'h00, reset value of every control register

Ports:
i_Clk  input  1  system clock; same clock as the SPI slave byte interface
i_Rst  input  1  reset, synchronous, active-high
i_RX_DV  input  1  one-cycle pulse: i_RX_Byte valid (from SPI slave o_RX_DV)
i_RX_Byte  input  8  received byte
i_SPI_CS_n  input  1  chip select from master, active-low; already synchronised to i_Clk
i_Fsm_State  input  STATE_W  current status-FSM state
o_TX_DV  output  1  one-cycle pulse: load o_TX_Byte into SPI slave
o_TX_Byte  output  8  response byte for the next SPI transfer
o_Ctrl_Regs  output  8*NUM_REGS  flattened control registers; reg k is bits [8k+7:8k]
o_Err_Cnt  output  8  saturating protocol-error counter
o_Busy  output  1  high while in WAIT_DATA

Behaviour:
- Reset (i_Rst high at a clock edge) has these effects:
  - state goes to IDLE.
  - o_TX_DV goes to 0 and o_TX_Byte goes to 8'h00.
  - all control registers go to REG_RST.
  - o_Err_Cnt goes to 0 and o_Busy goes to 0.
  - Reset mid-command discards the pending write.
- Command encoding (first byte of a transaction):
  - 8'hFF is GET_STATE. Response is i_Fsm_State zero-extended to 8 bits.
  - 8'h00 is NOP. Response is 8'h00.
  - 8'b10xx_xxaa is READ reg aa.
    - aa < NUM_REGS: response is reg[aa].
    - aa == 3: response is o_Err_Cnt.
    - Any other aa (aa < 3 but aa >= NUM_REGS) is an error.
  - 8'b01xx_xxaa is WRITE reg aa. The next byte is the data; aa >= NUM_REGS is an error.
  - Everything else is an error.
- States:
  - IDLE: on i_RX_DV, decode the byte.
    - GET_STATE, NUM or valid READ: stay in IDLE and respond.
    - Valid WRITE: latch aa, go to WAIT_DATA, respond 8'hA5 (ACK).
    - Error: increment o_Err_Cnt, respond 8'hEE (NAK), stay in IDLE.
  - WAIT_DATA: on i_RX_DV, write i_RX_Byte to reg[aa], respond 8'hA5, return to IDLE.
    - If i_SPI_CS_n is high without i_RX_DV: abort, increment o_Err_Cnt, return to IDLE, no register write, no response.
- Latency:
  - o_TX_DV pulses exactly one cycle, in the cycle after i_RX_DV, with o_TX_Byte valid in that same cycle.
  - o_TX_Byte holds its value until the next response.
  - Register writes are visible on o_Ctrl_Regs in the cycle after the data byte's i_RX_DV.
- GET_STATE samples i_Fsm_State in the i_RX_DV cycle.
- o_Err_Cnt saturates at 8'hFF (no wrap).
- Simultaneous i_RX_DV and i_SPI_CS_n high in WAIT_DATA: the byte is complete, so the write proceeds; no abort.
- i_SPI_CS_n high in IDLE has no effect.
- i_RX_DV while o_TX_DV is pulsing is handled normally. Back-to-back i_RX_DV on consecutive cycles must be accepted.
- o_Busy = (state == WAIT_DATA), registered.

Decomposition:
- Shared package spi_cmd_pkg holds:
  - command constants: CMD_GET_STATE=8'hFF, CMD_NOP=8'h00, READ prefix 2'b10, WRITE prefix 2'b01.
  - response constants: RSP_ACK=8'hA5, RSP_NAK=8'hEE.
  - ERR_REG_ADDR=2'd3.
  - the state enum {IDLE, WAIT_DATA}.
- One natural sub-module: spi_cmd_regbank holds the NUM_REGS registers with write-enable/address/data and a read mux. The controller FSM and error counter stay in spi_cmd_ctrl.

Test Plan:
- Reset, then check outputs: o_Ctrl_Regs all 8'h00, o_Err_Cnt=0, o_TX_DV=0, o_Busy=0.
- i_Fsm_State=2'b10, RX 8'hFF -> next cycle o_TX_DV=1, o_TX_Byte=8'h02.
- RX 8'h41 then RX 8'h3C:
  - first byte: ACK 8'hA5, o_Busy=1.
  - second byte: reg1=8'h3C, ACK 8'hA5, o_Busy=0.
  - then RX 8'h81 -> o_TX_Byte=8'h3C.
- RX 8'h42, then raise i_SPI_CS_n before the data byte -> return to IDLE, reg2 unchanged, o_Err_Cnt=1. Then RX 8'h83 -> o_TX_Byte=8'h01.
- RX 8'h43 (write to read-only addr 3) and RX 8'h20 (illegal) -> two NAK 8'hEE responses, o_Err_Cnt=2, no register change. 300 illegal bytes -> o_Err_Cnt holds 8'hFF.
- RX 8'h40, then assert i_Rst before the data byte -> IDLE, all regs 8'h00, o_Busy=0. A following RX 8'hFF is answered normally.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command controller.
package spi_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 2;

  localparam logic [BYTE_W-1:0] CMD_GET_STATE = 8'hFF;
  localparam logic [BYTE_W-1:0] CMD_NOP       = 8'h00;
  localparam logic [1:0]        PFX_READ      = 2'b10;
  localparam logic [1:0]        PFX_WRITE     = 2'b01;

  localparam logic [BYTE_W-1:0] RSP_ACK = 8'hA5;
  localparam logic [BYTE_W-1:0] RSP_NAK = 8'hEE;

  localparam logic [ADDR_W-1:0] ERR_REG_ADDR = 2'd3;
  localparam logic [BYTE_W-1:0] ERR_CNT_MAX  = 8'hFF;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_e;

endpackage

// File: rtl/spi_cmd_regbank.sv
// Bank of byte-wide control registers with one write port and a combinational read mux.
module spi_cmd_regbank
  import spi_cmd_pkg::*;
#(
  parameter int unsigned      NUM_REGS = 3,
  parameter logic [BYTE_W-1:0] REG_RST = 8'h00
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [BYTE_W-1:0]          wr_data_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  output logic [BYTE_W-1:0]          rd_data_c_o,
  output logic [BYTE_W*NUM_REGS-1:0] regs_o
);

  logic [NUM_REGS-1:0][BYTE_W-1:0] regs_q;

  // Register storage; only the addressed entry takes the write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= {NUM_REGS{REG_RST}};
    end else begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (we_i && (wr_addr_i == ADDR_W'(k))) begin
          regs_q[k] <= wr_data_i;
        end
      end
    end
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rd_data_c_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (rd_addr_i == ADDR_W'(k)) begin
        rd_data_c_o = regs_q[k];
      end
    end
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes received bytes, answers reads, sequences register writes.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int unsigned       STATE_W  = 2,
  parameter int unsigned       NUM_REGS = 3,
  parameter logic [BYTE_W-1:0] REG_RST  = 8'h00
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_RX_DV,
  input  logic [BYTE_W-1:0]          i_RX_Byte,
  input  logic                       i_SPI_CS_n,
  input  logic [STATE_W-1:0]         i_Fsm_State,
  output logic                       o_TX_DV,
  output logic [BYTE_W-1:0]          o_TX_Byte,
  output logic [BYTE_W*NUM_REGS-1:0] o_Ctrl_Regs,
  output logic [BYTE_W-1:0]          o_Err_Cnt,
  output logic                       o_Busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                tx_dv_q, tx_dv_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic [BYTE_W-1:0]   err_cnt_q, err_cnt_d;
  logic                busy_q;

  logic                err_inc_c;
  logic                we_c;
  logic [ADDR_W-1:0]   rx_addr_c;
  logic                addr_ok_c;
  logic [1:0]          rx_pfx_c;
  logic [BYTE_W-1:0]   rd_data_c;

  assign rx_addr_c = i_RX_Byte[ADDR_W-1:0];
  assign rx_pfx_c  = i_RX_Byte[BYTE_W-1:BYTE_W-2];
  assign addr_ok_c = (32'(rx_addr_c) < NUM_REGS);

  spi_cmd_regbank #(
    .NUM_REGS (NUM_REGS),
    .REG_RST  (REG_RST)
  ) u_regbank (
    .clk_i       (i_Clk),
    .rst_i       (i_Rst),
    .we_i        (we_c),
    .wr_addr_i   (addr_q),
    .wr_data_i   (i_RX_Byte),
    .rd_addr_i   (rx_addr_c),
    .rd_data_c_o (rd_data_c),
    .regs_o      (o_Ctrl_Regs)
  );

  // Next-state, response and error-count logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    err_inc_c = 1'b0;
    we_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_RX_DV) begin
          tx_dv_d = 1'b1;
          if (i_RX_Byte == CMD_GET_STATE) begin
            tx_byte_d = BYTE_W'(i_Fsm_State);
          end else if (i_RX_Byte == CMD_NOP) begin
            tx_byte_d = CMD_NOP;
          end else if ((rx_pfx_c == PFX_READ) && (rx_addr_c == ERR_REG_ADDR)) begin
            tx_byte_d = err_cnt_q;
          end else if ((rx_pfx_c == PFX_READ) && addr_ok_c) begin
            tx_byte_d = rd_data_c;
          end else if ((rx_pfx_c == PFX_WRITE) && addr_ok_c) begin
            addr_d    = rx_addr_c;
            state_d   = WAIT_DATA;
            tx_byte_d = RSP_ACK;
          end else begin
            err_inc_c = 1'b1;
            tx_byte_d = RSP_NAK;
          end
        end
      end
      WAIT_DATA: begin
        // A completed byte wins over a simultaneous chip-select release.
        if (i_RX_DV) begin
          we_c      = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = RSP_ACK;
          state_d   = IDLE;
        end else if (i_SPI_CS_n) begin
          err_inc_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_cnt_d = (err_inc_c && (err_cnt_q != ERR_CNT_MAX)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // State and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= (state_d == WAIT_DATA);
    end
  end

  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = tx_byte_q;
  assign o_Err_Cnt = err_cnt_q;
  assign o_Busy    = busy_q;

endmodule
